// File: rtl/mem_access.sv
// RV32I load/store stage: ALU ops retire next cycle, memory ops run IDLE->REQ(->WAIT) with a bounded wait.
// Results appear as a one-cycle valid_o pulse; ready_o is low while an access is outstanding.
module mem_access #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] alu_o,
  output logic [31:0] mem_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, mem_q, mem_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q, f3_d;
  logic          we_q, we_d, valid_q, valid_d, mis_q, mis_d, tmo_q, tmo_d;
  logic          is_mem, legal, misal, accept, expire;
  logic [31:0]   rd_sh, ld_ext, st_wdata;
  logic [3:0]    st_be;

  assign is_mem = mem_rd_i | mem_wr_i;

  // A simultaneous read and write is handled as a load, so legality follows the load table.
  always_comb begin
    legal = 1'b0;
    if (mem_rd_i) begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    misal = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misal = alu_res_i[0];
      2'b10:   misal = |alu_res_i[1:0];
      default: misal = 1'b0;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_res_i[1:0];
        st_wdata = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << alu_res_i[1:0];
        st_wdata = {2{store_data_i[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data_i;
      end
    endcase
  end

  assign rd_sh = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = rd_sh;
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_ext = {24'b0, rd_sh[7:0]};
      3'b101:  ld_ext = {16'b0, rd_sh[15:0]};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  assign accept  = (state_q == IDLE) && valid_i && is_mem && legal && !misal;
  assign cnt_inc = cnt_q + CW'(1);
  // A strobe arriving in the final counted cycle still completes the access.
  assign expire  = (cnt_inc == CW'(TIMEOUT_CYC)) &&
                   (((state_q == REQ) && !dmem_gnt_i) || ((state_q == WAIT) && !dmem_rvalid_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = we_q ? IDLE : WAIT;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i || expire) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    mis_d   = 1'b0;
    tmo_d   = 1'b0;
    alu_d   = alu_q;
    mem_d   = mem_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!is_mem) begin
            valid_d = 1'b1;
            alu_d   = alu_res_i;
            mem_d   = '0;
          end else if (!legal || misal) begin
            valid_d = 1'b1;
            mis_d   = 1'b1;
            alu_d   = alu_res_i;
            mem_d   = '0;
          end else begin
            addr_d  = alu_res_i;
            we_d    = !mem_rd_i;
            f3_d    = funct3_i;
            be_d    = mem_rd_i ? 4'b0000 : st_be;
            wdata_d = mem_rd_i ? 32'b0 : st_wdata;
          end
        end
      end
      REQ: begin
        if ((dmem_gnt_i && we_q) || expire) begin
          valid_d = 1'b1;
          tmo_d   = expire;
          alu_d   = addr_q;
          mem_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i || expire) begin
          valid_d = 1'b1;
          tmo_d   = expire;
          alu_d   = addr_q;
          mem_d   = dmem_rvalid_i ? ld_ext : 32'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
      alu_q   <= '0;
      mem_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else begin
      valid_q <= valid_d;
      mis_q   <= mis_d;
      tmo_q   <= tmo_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
    end
  end

  assign ready_o      = (state_q == IDLE);
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign alu_o        = alu_q;
  assign mem_o        = mem_q;
  assign valid_o      = valid_q;
  assign misalign_o   = mis_q;
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected write-back results are queued at issue and popped on valid_o.
module tb_mem_access;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, mem_rd_i, mem_wr_i;
  logic [31:0] alu_res_i, store_data_i;
  logic [2:0]  funct3_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] alu_o, mem_o;
  logic        valid_o, misalign_o, timeout_o;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] mem;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .alu_res_i(alu_res_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .alu_o(alu_o), .mem_o(mem_o), .valid_o(valid_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void push(input logic [31:0] a, input logic [31:0] m, input logic mis, input logic tmo);
    exp_t e;
    e.alu = a; e.mem = m; e.mis = mis; e.tmo = tmo;
    sb.push_back(e);
  endfunction

  // Scoreboard: every valid_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid_o", 32'(valid_o), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("alu_o", alu_o, mon_e.alu);
          chk("mem_o", mem_o, mon_e.mem);
          chk("misalign_o", 32'(misalign_o), 32'(mon_e.mis));
          chk("timeout_o", 32'(timeout_o), 32'(mon_e.tmo));
        end
      end else if (misalign_o || timeout_o) begin
        chk("flag_without_valid", {30'b0, misalign_o, timeout_o}, 32'd0);
      end
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] sd);
    int n = 0;
    while (!ready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (!ready_o) chk("ready_wait", 32'(ready_o), 32'd1);
    valid_i = 1'b1; mem_rd_i = rd; mem_wr_i = wr; funct3_i = f3;
    alu_res_i = a; store_data_i = sd;
    @(posedge clk); #1;
    valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
  endtask

  task automatic resp(input int gw, input logic load, input int rw, input logic [31:0] rdata);
    repeat (gw) begin @(posedge clk); #1; end
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    if (load) begin
      repeat (rw) begin @(posedge clk); #1; end
      dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
      @(posedge clk); #1;
      dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!valid_o && n < 40);
    chk(tag, 32'(valid_o), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {26'b0, dmem_req_o, dmem_we_o, valid_o, misalign_o, timeout_o, 1'b0}, 32'd0);
    chk({tag, "_be"}, 32'(dmem_be_o), 32'd0);
    chk({tag, "_addr"}, dmem_addr_o, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    chk({tag, "_alu"}, alu_o, 32'd0);
    chk({tag, "_mem"}, mem_o, 32'd0);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int n, k;
    rst = 1'b0; valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; funct3_i = '0;
    alu_res_i = '0; store_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(ready_o), 32'd1);
    @(posedge clk); #1;

    // ALU ops, back to back
    push(32'h12345678, 0, 0, 0); op(0, 0, 3'b000, 32'h12345678, 0);
    push(32'hCAFEF00D, 0, 0, 0); op(0, 0, 3'b000, 32'hCAFEF00D, 0);

    // LB / LBU at byte 3
    push(32'h103, 32'hFFFFFF80, 0, 0); op(1, 0, 3'b000, 32'h103, 0);
    @(negedge clk);
    chk("lb_req", 32'(dmem_req_o), 32'd1);
    chk("lb_addr", dmem_addr_o, 32'h100);
    chk("lb_we_be", {27'b0, dmem_we_o, dmem_be_o}, 32'd0);
    resp(1, 1, 0, 32'h80AABBCC);
    push(32'h103, 32'h00000080, 0, 0); op(1, 0, 3'b100, 32'h103, 0);
    resp(1, 1, 0, 32'h80AABBCC);

    // halfword / word loads
    push(32'h102, 32'hFFFF80AA, 0, 0); op(1, 0, 3'b001, 32'h102, 0); resp(0, 1, 1, 32'h80AABBCC);
    push(32'h100, 32'h0000BBCC, 0, 0); op(1, 0, 3'b101, 32'h100, 0); resp(2, 1, 0, 32'h80AABBCC);
    push(32'h104, 32'h80AABBCC, 0, 0); op(1, 0, 3'b010, 32'h104, 0); resp(0, 1, 0, 32'h80AABBCC);

    // stores
    push(32'h102, 0, 0, 0); op(0, 1, 3'b001, 32'h102, 32'h0000BEEF);
    @(negedge clk);
    chk("sh_be", 32'(dmem_be_o), 32'hC);
    chk("sh_wdata", dmem_wdata_o, 32'hBEEFBEEF);
    chk("sh_addr", dmem_addr_o, 32'h100);
    chk("sh_req_we", {30'b0, dmem_req_o, dmem_we_o}, 32'd3);
    @(negedge clk);
    chk("sh_hold", {dmem_wdata_o[31:4], dmem_be_o}, {28'hBEEFBEE, 4'hC});
    resp(1, 0, 0, 0);
    push(32'h201, 0, 0, 0); op(0, 1, 3'b000, 32'h201, 32'h123456A5);
    @(negedge clk);
    chk("sb_be", 32'(dmem_be_o), 32'h2);
    chk("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
    resp(0, 0, 0, 0);
    push(32'h300, 0, 0, 0); op(0, 1, 3'b010, 32'h300, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_be_wdata", dmem_wdata_o ^ {28'b0, dmem_be_o}, 32'hDEADBEE0);
    resp(0, 0, 0, 0);

    // read and write together -> load
    push(32'h104, 32'h11223344, 0, 0); op(1, 1, 3'b010, 32'h104, 32'hFFFFFFFF);
    @(negedge clk);
    chk("rdwr_we_be", {27'b0, dmem_we_o, dmem_be_o}, 32'd0);
    resp(0, 1, 0, 32'h11223344);

    // misaligned and illegal
    push(32'h102, 0, 1, 0); op(1, 0, 3'b010, 32'h102, 0);
    @(negedge clk);
    chk("mis_lw_noreq", 32'(dmem_req_o), 32'd0);
    push(32'h101, 0, 1, 0); op(1, 0, 3'b001, 32'h101, 0);
    push(32'h100, 0, 1, 0); op(0, 1, 3'b100, 32'h100, 0);
    push(32'h100, 0, 1, 0); op(1, 0, 3'b011, 32'h100, 0);

    // grant never comes
    push(32'h400, 0, 0, 1); op(1, 0, 3'b010, 32'h400, 0);
    n = 0; k = 0;
    do begin @(negedge clk); if (dmem_req_o) k++; n++; end while (!valid_o && n < 40);
    chk("tmo_req_cycles", 32'(k), 32'd16);
    chk("tmo_valid", 32'(valid_o), 32'd1);
    chk("tmo_ready", 32'(ready_o), 32'd1);

    // strobe in the final counted cycle wins
    push(32'h500, 0, 0, 0); op(0, 1, 3'b010, 32'h500, 32'h1); resp(TMO - 1, 0, 0, 0);
    push(32'h504, 32'h55667788, 0, 0); op(1, 0, 3'b010, 32'h504, 0); resp(0, 1, TMO - 1, 32'h55667788);

    // rvalid never comes
    push(32'h508, 0, 0, 1); op(1, 0, 3'b010, 32'h508, 0); resp(0, 0, 0, 0);
    wait_valid("wait_tmo_valid");

    // reset while in WAIT, late rvalid afterwards
    op(1, 0, 3'b010, 32'h600, 0); resp(0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_in_wait");
    @(posedge clk); #1;
    rst = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("after_late_rvalid");

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 16, maximum cycles waited for dmem_gnt_i or dmem_rvalid_i before abort.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 valid_i  in  1  execute-stage op present.
REQ-005 ready_o  out  1  block can accept an op this cycle.
REQ-006 alu_res_i  in  32  ALU result; also the effective address for loads and stores.
REQ-007 store_data_i  in  32  rs2 data for stores.
REQ-008 funct3_i  in  3  access size/sign, RV32I encoding.
REQ-009 mem_rd_i / mem_wr_i  in  1 each  load / store request.
REQ-010 dmem_req_o  out  1  request to data memory, held until grant.
REQ-011 dmem_we_o  out  1  1 = write.
REQ-012 dmem_addr_o  out  32  word-aligned address ({alu_res_i[31:2],2'b00}).
REQ-013 dmem_be_o  out  4  byte enables.
REQ-014 dmem_wdata_o  out  32  lane-aligned store data.
REQ-015 dmem_gnt_i / dmem_rvalid_i  in  1 each  request accepted / read data valid.
REQ-016 dmem_rdata_i  in  32  read word.
REQ-017 alu_o  out  32  registered ALU result to write-back.
REQ-018 mem_o  out  32  registered, extended load data to write-back.
REQ-019 valid_o  out  1  one-cycle pulse: alu_o/mem_o/flags updated.
REQ-020 misalign_o / timeout_o  out  1 each  error flags, qualified by valid_o.

Function
REQ-021 FSM states: IDLE, REQ, WAIT; ready_o SHALL be 1 only in IDLE.
REQ-022 IDLE, valid_i=1, no mem op: alu_o<=alu_res_i, mem_o<=0, valid_o=1 on next cycle; stay IDLE (1-cycle latency, back-to-back ops accepted).
REQ-023 IDLE, valid_i=1, mem op, aligned, legal funct3: capture address, data, funct3, direction; go REQ.
REQ-024 mem_rd_i and mem_wr_i both 1: treated as load only.
REQ-025 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; any other value is illegal and reported as misalign_o.
REQ-026 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; no dmem request; next cycle valid_o=1, misalign_o=1, mem_o=0, alu_o=address; stay IDLE.
REQ-027 REQ: dmem_req_o=1 with addr/we/be/wdata stable until the cycle dmem_gnt_i=1.
- Store granted: return to IDLE, valid_o next cycle.
- Load granted: go WAIT.
REQ-028 WAIT: on dmem_rvalid_i=1, extend and register data into mem_o, valid_o next cycle, return to IDLE; dmem_rvalid_i in other states is ignored.
REQ-029 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; dmem_be_o=0 for loads.
REQ-030 Store data: SB byte replicated to all 4 lanes; SH halfword replicated to both halves; SW unchanged.
REQ-031 Load extraction: select byte/halfword by addr[1:0]; LB/LH sign-extend to 32 bits, LBU/LHU zero-extend.
REQ-032 Wait counter: cleared on entry to REQ and on entry to WAIT, incremented each cycle in REQ or WAIT; on reaching TIMEOUT_CYC without the expected strobe, drop dmem_req_o, return to IDLE, pulse valid_o with timeout_o=1 and mem_o=0.
REQ-033 Grant or rvalid in the same cycle the counter reaches TIMEOUT_CYC: the strobe wins; no timeout.
REQ-034 valid_o, misalign_o, timeout_o SHALL be single-cycle pulses; alu_o/mem_o hold their values until the next update.

Reset
REQ-035 rst=0 asynchronously forces IDLE, wait counter 0, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, alu_o=0, mem_o=0, valid_o=0, misalign_o=0, timeout_o=0.
REQ-036 Reset during REQ or WAIT SHALL abandon the access with no valid_o pulse; a late dmem_rvalid_i after release is ignored.
REQ-037 ready_o=1 in the first cycle after reset release.

Verification
REQ-038 ALU op alu_res_i=0x12345678, no mem op -> next cycle valid_o=1, alu_o=0x12345678, mem_o=0.
REQ-039 LB addr=0x103, rdata=0x80AABBCC, gnt after 2 cycles, rvalid 1 cycle later -> mem_o=0xFFFFFF80; LBU same data -> 0x00000080.
REQ-040 SH addr=0x102, store_data=0x0000BEEF -> dmem_be_o=4'b1100, dmem_wdata_o=0xBEEFBEEF, dmem_addr_o=0x100, valid_o after gnt.
REQ-041 LW addr=0x102 -> no dmem_req_o, next cycle valid_o=1, misalign_o=1.
REQ-042 Load with gnt never asserted, TIMEOUT_CYC=16 -> dmem_req_o high 16 cycles, then valid_o=1, timeout_o=1, ready_o=1.
REQ-043 rst=0 while in WAIT, then rvalid after release -> no valid_o, all outputs 0, ready_o=1.
